// File: rtl/muldiv_pkg.sv
// Shared codes and types for the iterative HI/LO multiply/divide controller.
package muldiv_pkg;

   localparam int ITER  = 32;
   localparam int ACC_W = 65;  // 33-bit upper half (carry/partial remainder) + 32-bit lower half

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MTHI  = 3'd1;
   localparam logic [2:0] OP_MTLO  = 3'd2;
   localparam logic [2:0] OP_MULTU = 3'd3;
   localparam logic [2:0] OP_DIV   = 3'd4;
   localparam logic [2:0] OP_DIVU  = 3'd5;

   typedef enum logic [1:0] {
      SEL_MT    = 2'd0,
      SEL_MULTU = 2'd1,
      SEL_DIV   = 2'd2,
      SEL_DIVU  = 2'd3
   } sel_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_e;

   typedef enum logic {
      IT_MUL,
      IT_DIV
   } iter_mode_e;

   function automatic logic [31:0] mag32(input logic is_signed, input logic [31:0] v);
      return (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational step of unsigned shift-add multiply or restoring divide.
module muldiv_iter
   import muldiv_pkg::*;
(
   input  iter_mode_e         mode,
   input  logic [ACC_W-1:0]   acc,
   input  logic [31:0]        operand,
   output logic [ACC_W-1:0]   acc_next
);

   logic [32:0]      sum;
   logic [ACC_W-1:0] shifted;
   logic [32:0]      diff;

   assign sum     = {1'b0, acc[63:32]} + {1'b0, operand};
   assign shifted = {acc[63:0], 1'b0};
   assign diff    = shifted[64:32] - {1'b0, operand};

   // NOTE: acc_next gets a value on every path through this block, so no latch is inferred.
   always_comb begin
      acc_next = acc;
      if (mode == IT_MUL) begin
         // Multiplier bits sit in the low half and are consumed LSB first.
         if (acc[0]) acc_next = {1'b0, sum, acc[31:1]};
         else        acc_next = {1'b0, acc[64:1]};
      end else begin
         if (shifted[64:32] >= {1'b0, operand}) acc_next = {diff, shifted[31:1], 1'b1};
         else                                   acc_next = shifted;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO register file with an iterative multu/div/divu engine and mthi/mtlo writes.
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [1:0]  sel
);

   state_e           state_q, state_nx;
   sel_e             sel_q;
   logic [ACC_W-1:0] acc_q, acc_step;
   logic [31:0]      opnd_q, hi_q, lo_q;
   logic [5:0]       cnt_q;
   logic             neg_quo_q, neg_rem_q;
   logic             ld_mthi, ld_mtlo, ld_mul, ld_div, wr_mul;
   logic             is_div, div_zero;
   iter_mode_e       mode;

   assign is_div   = (op == OP_DIV);
   assign div_zero = (rt == 32'd0);
   assign mode     = (sel_q == SEL_MULTU) ? IT_MUL : IT_DIV;

   muldiv_iter u_iter (
      .mode     (mode),
      .acc      (acc_q),
      .operand  (opnd_q),
      .acc_next (acc_step)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      busy     = 1'b0;
      done     = 1'b0;
      ld_mthi  = 1'b0;
      ld_mtlo  = 1'b0;
      ld_mul   = 1'b0;
      ld_div   = 1'b0;
      wr_mul   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MTHI:         begin ld_mthi = 1'b1; state_nx = S_DONE; end
                  OP_MTLO:         begin ld_mtlo = 1'b1; state_nx = S_DONE; end
                  OP_MULTU:        begin ld_mul  = 1'b1; state_nx = S_RUN;  end
                  OP_DIV, OP_DIVU: begin
                     ld_div   = 1'b1;
                     state_nx = div_zero ? S_FIX : S_RUN;
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt_q == 6'd1) begin
               wr_mul   = (sel_q == SEL_MULTU);
               state_nx = (sel_q == SEL_MULTU) ? S_DONE : S_FIX;
            end
         end
         S_FIX: begin
            busy     = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: every datapath register is reset so an aborted operation leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q     <= SEL_MT;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         if (ld_mthi) begin hi_q <= rs; sel_q <= SEL_MT; end
         if (ld_mtlo) begin lo_q <= rs; sel_q <= SEL_MT; end
         if (ld_mul) begin
            sel_q     <= SEL_MULTU;
            opnd_q    <= rs;
            acc_q     <= {33'd0, rt};
            cnt_q     <= 6'(ITER);
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
         end
         if (ld_div) begin
            sel_q  <= is_div ? SEL_DIV : SEL_DIVU;
            opnd_q <= mag32(is_div, rt);
            if (div_zero) begin
               // Divide by zero goes straight to FIX with the architectural result preloaded.
               acc_q     <= {1'b0, rs, 32'hFFFF_FFFF};
               cnt_q     <= 6'd0;
               neg_quo_q <= 1'b0;
               neg_rem_q <= 1'b0;
            end else begin
               acc_q     <= {33'd0, mag32(is_div, rs)};
               cnt_q     <= 6'(ITER);
               neg_quo_q <= is_div && (rs[31] ^ rt[31]);
               neg_rem_q <= is_div && rs[31];
            end
         end
         if (state_q == S_RUN) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - 6'd1;
            if (wr_mul) {hi_q, lo_q} <= acc_step[63:0];
         end
         if (state_q == S_FIX) begin
            hi_q <= neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            lo_q <= neg_quo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
         end
      end
   end

   assign hi  = hi_q;
   assign lo  = lo_q;
   assign sel = sel_q;

endmodule
